// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token codes, receiver FSM state type and token classifier.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

    // Returns {is_ctrl, ctrl[1:0]}; ctrl is 0 for data symbols.
    function automatic logic [2:0] token_decode(input logic [9:0] word);
        return word == CTRL_00 ? 3'b100 :
               word == CTRL_01 ? 3'b101 :
               word == CTRL_10 ? 3'b110 :
               word == CTRL_11 ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational 10b TMDS data symbol to 8-bit byte decode.
module tmds_word_decode (
    input  logic [9:0] word,
    output logic [7:0] data
);

    logic [7:0] q;

    assign q    = word[9] ? ~word[7:0] : word[7:0];
    // word[8] selects XOR (1) or XNOR (0) transition coding of the original byte.
    assign data = {q[7:1] ^ q[6:0] ^ {7{~word[8]}}, q[0]};

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS receive channel -- bit-slip word alignment, lock tracking, 2-cycle symbol decode.
// Define TMDS_DEC_SLIP_CNT_EN to add the saturating slip_count_out port.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic       bitslip_out,
    output logic       locked_out,
    output logic       de_out,
    output logic [7:0] data_out,
`ifdef TMDS_DEC_SLIP_CNT_EN
    output logic [7:0] slip_count_out,
`endif
    output logic [1:0] control_out
);

    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int RW = $clog2(LOCK_TOKENS + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(SEARCH_TIMEOUT);
    localparam logic [TW-1:0] TO_TRIP  = TW'(SEARCH_TIMEOUT - 2);
    localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_TOKENS);
    localparam logic [RW-1:0] RUN_TRIP = RW'(LOCK_TOKENS - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(SLIP_WAIT);
    localparam logic [WW-1:0] WAIT_TRIP = WW'(SLIP_WAIT - 1);

    state_t          state, state_n;
    logic [TW-1:0]   to_cnt, to_n, to_inc;
    logic [RW-1:0]   run_cnt, run_n, run_inc;
    logic [WW-1:0]   wait_cnt, wait_n, wait_inc;
    logic            slip_n;
    logic [2:0]      tok;
    logic [9:0]      s1_word;
    logic            s1_ctrl;
    logic [1:0]      s1_cval;
    logic [7:0]      dec;

    assign tok        = token_decode(tmds_in);
    assign locked_out = state == LOCKED;
    assign to_inc     = to_cnt == TO_MAX ? to_cnt : to_cnt + 1'b1;
    assign run_inc    = run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1;
    assign wait_inc   = wait_cnt == WAIT_MAX ? wait_cnt : wait_cnt + 1'b1;

    tmds_word_decode u_word_decode (
        .word (s1_word),
        .data (dec)
    );

    // Thresholds compare against the value the counter is about to take.
    always_comb begin
        state_n = state;
        to_n    = to_cnt;
        run_n   = run_cnt;
        wait_n  = wait_cnt;
        slip_n  = 1'b0;
        case (state)
            SEARCH: begin
                if (s1_ctrl && run_cnt == RUN_TRIP) begin
                    state_n = LOCKED;
                    to_n    = '0;
                    run_n   = '0;
                end else if (to_cnt == TO_TRIP) begin
                    state_n = tmds_pkg::SLIP_WAIT;
                    slip_n  = 1'b1;
                    to_n    = '0;
                    run_n   = '0;
                end else begin
                    run_n = s1_ctrl ? run_inc : '0;
                    to_n  = to_inc;
                end
            end
            tmds_pkg::SLIP_WAIT: begin
                state_n = wait_cnt == WAIT_TRIP ? SEARCH : state;
                wait_n  = wait_cnt == WAIT_TRIP ? '0 : wait_inc;
            end
            LOCKED: begin
                state_n = !s1_ctrl && to_cnt == TO_TRIP ? SEARCH : state;
                to_n    = s1_ctrl || to_cnt == TO_TRIP ? '0 : to_inc;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= SEARCH;
            to_cnt      <= '0;
            run_cnt     <= '0;
            wait_cnt    <= '0;
            bitslip_out <= 1'b0;
            s1_word     <= '0;
            s1_ctrl     <= 1'b0;
            s1_cval     <= '0;
            de_out      <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
        end else begin
            state       <= state_n;
            to_cnt      <= to_n;
            run_cnt     <= run_n;
            wait_cnt    <= wait_n;
            bitslip_out <= slip_n;
            s1_word     <= tmds_in;
            s1_ctrl     <= tok[2];
            s1_cval     <= tok[1:0];
            de_out      <= locked_out && !s1_ctrl;
            data_out    <= locked_out && !s1_ctrl ? dec : '0;
            control_out <= locked_out && s1_ctrl ? s1_cval : control_out;
        end
    end

`ifdef TMDS_DEC_SLIP_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            slip_count_out <= '0;
        else if (bitslip_out && slip_count_out != 8'hff)
            slip_count_out <= slip_count_out + 1'b1;
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed/random bench with a TMDS encoder, a bit-slipping deserializer and a behavioural receiver model.
module tb_tmds_decoder;

    localparam int LT = 8;
    localparam int TO = 64;
    localparam int SW = 4;
    localparam int M_SEARCH = 0;
    localparam int M_WAIT   = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] tmds = '0;
    logic       bitslip, locked, de;
    logic [7:0] data;
    logic [1:0] ctrl;
`ifdef TMDS_DEC_SLIP_CNT_EN
    logic [7:0] slip_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int disp = 0;
    int off = 0;
    int slips_seen = 0;
    int s0;
    logic [9:0] w_prev = '0;
    logic [7:0] r;

    int ms, run, to, wt, m_slips;
    logic p_ctrl;
    logic [1:0] p_cval;
    logic [7:0] p_byte;
    logic e_slip, e_de;
    logic [7:0] e_data;
    logic [1:0] e_ctrl;

    tmds_decoder #(.LOCK_TOKENS(LT), .SEARCH_TIMEOUT(TO), .SLIP_WAIT(SW)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .tmds_in       (tmds),
        .bitslip_out   (bitslip),
        .locked_out    (locked),
        .de_out        (de),
        .data_out      (data),
`ifdef TMDS_DEC_SLIP_CNT_EN
        .slip_count_out(slip_cnt),
`endif
        .control_out   (ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [9:0] tokval(input logic [1:0] c);
        return c == 2'd0 ? 10'b1101010100 : c == 2'd1 ? 10'b0010101011 :
               c == 2'd2 ? 10'b0101010100 : 10'b1010101011;
    endfunction

    function automatic logic [9:0] tokw(input logic [1:0] c);
        disp = 0;
        return tokval(c);
    endfunction

    function automatic logic [2:0] classify(input logic [9:0] w);
        for (int c = 0; c < 4; c++)
            if (w == tokval(2'(c))) return {1'b1, 2'(c)};
        return 3'b000;
    endfunction

    // Reference DVI transmitter encoder with running disparity.
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [8:0] qm;
        logic use_xnor;
        int bal;
        logic [9:0] q;
        use_xnor = ones(d) > 4 || (ones(d) == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
        qm[8] = !use_xnor;
        bal = 2 * ones(qm[7:0]) - 8;
        if (disp == 0 || bal == 0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? bal : -bal;
        end else if ((disp > 0 && bal > 0) || (disp < 0 && bal < 0)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) - bal;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += bal - 2 * (1 - int'(qm[8]));
        end
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        ms = M_SEARCH; run = 0; to = 0; wt = 0; m_slips = 0;
        p_ctrl = 1'b0; p_cval = '0; p_byte = '0;
        e_slip = 1'b0; e_de = 1'b0; e_data = '0; e_ctrl = '0;
    endfunction

    // One clock of the receiver: outputs reflect the previous word, then the word is classified.
    function automatic void model_step(input logic [9:0] w, input logic [7:0] b);
        logic [2:0] k;
        k = classify(w);
        e_de = ms == M_LOCKED && !p_ctrl;
        e_data = e_de ? p_byte : 8'h00;
        if (ms == M_LOCKED && p_ctrl) e_ctrl = p_cval;
        e_slip = 1'b0;
        if (ms == M_SEARCH) begin
            if (p_ctrl && run + 1 == LT) begin
                ms = M_LOCKED; run = 0; to = 0;
            end else if (to + 1 == TO - 1) begin
                ms = M_WAIT; run = 0; to = 0; e_slip = 1'b1;
                m_slips = m_slips < 255 ? m_slips + 1 : 255;
            end else begin
                run = p_ctrl ? run + 1 : 0;
                to++;
            end
        end else if (ms == M_WAIT) begin
            if (wt + 1 == SW) begin ms = M_SEARCH; wt = 0; end
            else wt++;
        end else begin
            if (p_ctrl) to = 0;
            else if (to + 1 == TO - 1) begin ms = M_SEARCH; to = 0; end
            else to++;
        end
        p_ctrl = k[2];
        p_cval = k[1:0];
        p_byte = b;
    endfunction

    // Puts one symbol on the wire; the deserializer window lags by 'off' bits.
    task automatic push(input logic [9:0] w, input logic [7:0] b);
        logic [19:0] pair;
        pair = {w, w_prev};
        tmds = pair[10 - off +: 10];
        w_prev = w;
        @(posedge clk);
        model_step(tmds, b);
        if (e_slip) off = (off + 1) % 10;
        #1;
        chk("cycle", {19'd0, bitslip, locked, de, data, ctrl},
            {19'd0, e_slip, ms == M_LOCKED, e_de, e_data, e_ctrl});
`ifdef TMDS_DEC_SLIP_CNT_EN
        chk("slip_count", slip_cnt, m_slips);
`endif
        if (bitslip) slips_seen++;
    endtask

    task automatic push_data();
        logic [7:0] v;
        v = 8'($urandom);
        push(enc(v), v);
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            tmds = 10'($urandom);
            @(posedge clk);
            #1;
            chk("reset", {bitslip, locked, de, data, ctrl}, 0);
        end
        rst_n = 1'b1;
        off = 0;
        disp = 0;
        w_prev = tokval(2'd0);
    endtask

    initial begin
        reset_cycles(4);
        repeat (TO - 2) push_data();
        chk("no_early_slip", slips_seen, 0);
        push_data();
        chk("first_slip", bitslip, 1);
        repeat (8) push_data();

        reset_cycles(2);
        repeat (LT) push(tokw(2'd0), 8'h00);
        chk("lock_early", locked, 0);
        push(tokw(2'd0), 8'h00);
        chk("lock_after_run", locked, 1);
        push(enc(8'h5a), 8'h5a);
        push(enc(8'h00), 8'h00);
        chk("data_5a", {de, data}, {1'b1, 8'h5a});
        push(enc(8'hff), 8'hff);
        chk("data_00", {de, data}, {1'b1, 8'h00});
        push(tokw(2'd0), 8'h00);
        chk("data_ff", {de, data}, {1'b1, 8'hff});
        push(tokw(2'd0), 8'h00);

        for (int c = 1; c < 4; c++) begin
            repeat (3) push(tokw(2'(c)), 8'h00);
            push_data();
            chk("ctrl_run", ctrl, c);
            repeat (4) push_data();
            chk("ctrl_hold", ctrl, c);
        end
        repeat (2) push(tokw(2'd0), 8'h00);

        s0 = slips_seen;
        repeat (TO - 1) push_data();
        chk("still_locked", locked, 1);
        push_data();
        chk("lock_lost", locked, 0);
        push_data();
        chk("lost_de", de, 0);
        chk("no_slip_on_loss", slips_seen - s0, 0);
        repeat (LT + 1) push(tokw(2'd0), 8'h00);
        chk("relock", locked, 1);

        reset_cycles(2);
        off = 3;
        slips_seen = 0;
        for (int i = 0; i < 2000 && !locked; i++) push(tokw(2'd0), 8'h00);
        chk("misalign_slips", slips_seen, 7);
        chk("misalign_lock", locked, 1);
        for (int i = 0; i < 16; i++) begin
            r = 8'hA5 + 8'(i);
            push(enc(r), r);
        end
        repeat (2) push(tokw(2'd0), 8'h00);

        repeat (3) push_data();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bitslip, locked, de, data, ctrl}, 0);
        reset_cycles(2);
        repeat (LT) push(tokw(2'd0), 8'h00);
        chk("relock_early", locked, 0);
        push(tokw(2'd0), 8'h00);
        chk("relock_full_run", locked, 1);
        repeat (4) push_data();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
